// File: rtl/four_12_12_st1_bias_ctrl.sv
// Bias-word controller: streams bias words into memory (LOAD) and plays them out to the neuron stage (READ).
// Define FOUR_12_12_BIAS_UPDATE_EN to compile in the read-modify-write UPDATE command.
module four_12_12_st1_bias_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             mem_rd_en,
  output logic [IW-1:0]    mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             mem_wr_en,
  output logic [IW-1:0]    mem_wr_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam logic [1:0]    OP_LOAD   = 2'd0;
  localparam logic [1:0]    OP_READ   = 2'd1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DEPTH - 1);

`ifdef FOUR_12_12_BIAS_UPDATE_EN
  localparam logic [1:0] OP_UPDATE = 2'd2;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD_ISSUE, S_RD_WAIT, S_UPD_RD, S_UPD_WR
  } state_t;
  logic [WIDTH-1:0] delta;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RD_ISSUE, S_RD_WAIT
  } state_t;
`endif

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt, idx_inc;
  logic          cmd_fire, load_fire, out_fire, idx_last;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign load_fire = load_valid & load_ready;
  assign out_fire  = out_valid & out_ready;
  assign idx_last  = (idx == IDX_LAST);
  assign idx_inc   = IW'(idx + IW'(1));

  // Next state and entry index
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          idx_nxt = '0;
          case (cmd_op)
            OP_LOAD:   state_nxt = S_LOAD;
            OP_READ:   state_nxt = S_RD_ISSUE;
`ifdef FOUR_12_12_BIAS_UPDATE_EN
            OP_UPDATE: state_nxt = S_UPD_RD;
`endif
            default:   state_nxt = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (load_fire) begin
          idx_nxt = idx_last ? '0 : idx_inc;
          if (idx_last) state_nxt = S_IDLE;
        end
      end
      S_RD_ISSUE: state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (out_fire) begin
          idx_nxt   = out_last ? '0 : idx_inc;
          state_nxt = out_last ? S_IDLE : S_RD_ISSUE;
        end
      end
`ifdef FOUR_12_12_BIAS_UPDATE_EN
      S_UPD_RD: if (load_fire) state_nxt = S_UPD_WR;
      S_UPD_WR: begin
        idx_nxt   = idx_last ? '0 : idx_inc;
        state_nxt = idx_last ? S_IDLE : S_UPD_RD;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Memory port: gated by reset so an abandoned operation issues nothing in the reset cycle
  always_comb begin
    mem_rd_addr = idx;
    mem_wr_addr = idx;
    mem_rd_en   = reset & (state == S_RD_ISSUE);
    mem_wr_en   = reset & (state == S_LOAD) & load_fire;
    mem_wr_data = load_data;
`ifdef FOUR_12_12_BIAS_UPDATE_EN
    if (state == S_UPD_RD) mem_rd_en = reset & load_fire;
    if (state == S_UPD_WR) begin
      mem_wr_en   = reset;
      mem_wr_data = mem_rd_data + delta;
    end
`endif
  end

  // State, handshakes and output capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      cmd_ready  <= 1'b0;
      load_ready <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      out_last   <= 1'b0;
`ifdef FOUR_12_12_BIAS_UPDATE_EN
      delta      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
`ifdef FOUR_12_12_BIAS_UPDATE_EN
      load_ready <= (state_nxt == S_LOAD) || (state_nxt == S_UPD_RD);
      if ((state == S_UPD_RD) && load_fire) delta <= load_data;
`else
      load_ready <= (state_nxt == S_LOAD);
`endif
      // read data arrives in the first RD_WAIT cycle; capture once and hold under backpressure
      if (out_fire) begin
        out_valid <= 1'b0;
      end else if ((state == S_RD_WAIT) && !out_valid) begin
        out_valid <= 1'b1;
        out_data  <= mem_rd_data;
        out_idx   <= idx;
        out_last  <= idx_last;
      end
    end
  end

endmodule

// File: tb/tb_four_12_12_st1_bias_ctrl.sv
// Scoreboard bench for four_12_12_st1_bias_ctrl: reference memory array plus expected-output queue.
module tb_four_12_12_st1_bias_ctrl;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IW-1:0]    idx;
    logic             last;
  } out_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic             load_valid, load_ready;
  logic [WIDTH-1:0] load_data;
  logic             mem_rd_en, mem_wr_en;
  logic [IW-1:0]    mem_rd_addr, mem_wr_addr;
  logic [WIDTH-1:0] mem_rd_data, mem_wr_data;
  logic             out_valid, out_ready, out_last, busy;
  logic [WIDTH-1:0] out_data;
  logic [IW-1:0]    out_idx;

  always #5 clk = ~clk;

  four_12_12_st1_bias_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  logic [WIDTH-1:0] mem      [DEPTH];
  logic [WIDTH-1:0] ref_mem  [DEPTH];
  logic [WIDTH-1:0] load_buf [DEPTH];
  out_t             exp_q [$];
  int               checks = 0, errors = 0;
  int               rd_cnt = 0, wr_cnt = 0;
  int               rd_per_idx [DEPTH];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bias memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // Monitor: pops expectations on every accepted output and polices hold/collision rules
  out_t             mon_e;
  bit               held = 0;
  logic [WIDTH-1:0] h_data;
  logic [IW-1:0]    h_idx;
  always @(negedge clk) begin
    if (reset) begin
      if (mem_rd_en) begin rd_cnt++; rd_per_idx[mem_rd_addr]++; end
      if (mem_wr_en) wr_cnt++;
      chk(!(mem_rd_en && mem_wr_en), "rd_wr_same_cycle", 64'(mem_wr_en), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_out", 64'(out_data), 64'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk(out_data == mon_e.data, "out_data", 64'(out_data), 64'(mon_e.data));
          chk(out_idx == mon_e.idx, "out_idx", 64'(out_idx), 64'(mon_e.idx));
          chk(out_last == mon_e.last, "out_last", 64'(out_last), 64'(mon_e.last));
        end
      end
      if (held) begin
        chk(out_valid, "hold_valid", 64'(out_valid), 64'd1);
        chk(out_data == h_data, "hold_data", 64'(out_data), 64'(h_data));
        chk(out_idx == h_idx, "hold_idx", 64'(out_idx), 64'(h_idx));
      end
      if (out_valid) chk(!mem_rd_en, "no_read_while_valid", 64'(mem_rd_en), 64'd0);
      held   = out_valid && !out_ready;
      h_data = out_data;
      h_idx  = out_idx;
    end else begin
      held = 0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_cmd(input logic [1:0] op);
    int n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    if (!cmd_ready) chk(1'b0, "cmd_ready_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input int nbeats, input bit gaps);
    do_cmd(2'd0);
    for (int i = 0; i < nbeats; i++) begin
      int n = 0;
      if (gaps) repeat ($urandom_range(0, 2)) step();
      while (!load_ready && n < 50) begin step(); n++; end
      if (!load_ready) chk(1'b0, "load_ready_timeout", 64'd0, 64'd1);
      load_valid = 1'b1;
      load_data  = load_buf[i];
      step();
      ref_mem[i] = load_buf[i];
      load_valid = 1'b0;
    end
    if (nbeats == DEPTH) chk(busy == 1'b0, "idle_after_load", 64'(busy), 64'd0);
  endtask

  task automatic do_read(input int stall_idx, input int stall_n, input bit rnd);
    int   base [DEPTH];
    int   got = 0, cyc = 0, left = stall_n;
    out_t e;
    for (int k = 0; k < DEPTH; k++) begin
      e.data = ref_mem[k];
      e.idx  = IW'(k);
      e.last = (k == DEPTH - 1);
      exp_q.push_back(e);
      base[k] = rd_per_idx[k];
    end
    do_cmd(2'd1);
    while (got < DEPTH && cyc < 400) begin
      if (out_valid && int'(out_idx) == stall_idx && left > 0) begin
        out_ready = 1'b0;
        left--;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid && out_ready) got++;
      step();
      cyc++;
    end
    out_ready = 1'b1;
    if (got < DEPTH) chk(1'b0, "read_timeout", 64'(got), 64'(DEPTH));
    chk(busy == 1'b0, "busy_after_read", 64'(busy), 64'd0);
    chk(cmd_ready == 1'b1, "cmd_ready_after_read", 64'(cmd_ready), 64'd1);
    chk(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k < DEPTH; k++)
      chk(rd_per_idx[k] - base[k] == 1, "reads_per_idx", 64'(rd_per_idx[k] - base[k]), 64'd1);
  endtask

  task automatic do_noop(input logic [1:0] op);
    int w0, r0;
    load_valid = 1'b1;
    load_data  = $urandom;
    w0 = wr_cnt;
    r0 = rd_cnt;
    do_cmd(op);
    chk(cmd_ready == 1'b1, "noop_cmd_ready", 64'(cmd_ready), 64'd1);
    chk(busy == 1'b0, "noop_busy", 64'(busy), 64'd0);
    chk(load_ready == 1'b0, "noop_load_ready", 64'(load_ready), 64'd0);
    step();
    load_valid = 1'b0;
    chk(wr_cnt == w0, "noop_no_write", 64'(wr_cnt - w0), 64'd0);
    chk(rd_cnt == r0, "noop_no_read", 64'(rd_cnt - r0), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; load_valid = 1'b0;
    load_data = '0; out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin rd_per_idx[k] = 0; ref_mem[k] = '0; end
    repeat (3) step();
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
    chk(out_data == '0, "rst_out_data", 64'(out_data), 64'd0);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(load_ready == 1'b0, "rst_load_ready", 64'(load_ready), 64'd0);
    chk(mem_rd_en == 1'b0 && mem_wr_en == 1'b0, "rst_mem_en", 64'({mem_rd_en, mem_wr_en}), 64'd0);
    chk(cmd_ready == 1'b0, "rst_cmd_ready", 64'(cmd_ready), 64'd0);
    reset = 1'b1;
    step();
    chk(cmd_ready == 1'b1, "cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    // Directed load then full-rate read-out
    load_buf[0] = 32'h11; load_buf[1] = 32'h22; load_buf[2] = 32'h33; load_buf[3] = 32'h44;
    do_load(DEPTH, 1'b0);
    do_read(-1, 0, 1'b0);

    // Backpressure on entry 1 for five cycles
    do_read(1, 5, 1'b0);

    // Reserved / disabled opcodes, with stray load_valid in IDLE
    do_noop(2'd3);
`ifndef FOUR_12_12_BIAS_UPDATE_EN
    do_noop(2'd2);
`endif

    // Reset after two beats of a new load: first two entries new, rest keep prior values
    load_buf[0] = 32'h55; load_buf[1] = 32'h66; load_buf[2] = 32'h77; load_buf[3] = 32'h88;
    do_load(2, 1'b0);
    reset = 1'b0;
    step();
    chk(out_valid == 1'b0, "rst_mid_load_out_valid", 64'(out_valid), 64'd0);
    chk(busy == 1'b0, "rst_mid_load_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    step();
    chk(cmd_ready == 1'b1, "cmd_ready_after_mid_reset", 64'(cmd_ready), 64'd1);
    do_read(-1, 0, 1'b0);

    // Reset while an output is held
    out_ready = 1'b0;
    do_cmd(2'd1);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk(out_valid == 1'b1, "valid_before_reset", 64'(out_valid), 64'd1);
    reset = 1'b0;
    step();
    chk(out_valid == 1'b0, "rst_mid_read_out_valid", 64'(out_valid), 64'd0);
    chk(out_data == '0, "rst_mid_read_out_data", 64'(out_data), 64'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    step();

`ifdef FOUR_12_12_BIAS_UPDATE_EN
    // UPDATE with +1 deltas: 0xFFFFFFFF wraps to zero
    load_buf[0] = 32'hFFFF_FFFF; load_buf[1] = 32'h1; load_buf[2] = 32'h2; load_buf[3] = 32'h3;
    do_load(DEPTH, 1'b0);
    do_cmd(2'd2);
    for (int i = 0; i < DEPTH; i++) begin
      n = 0;
      while (!load_ready && n < 50) begin step(); n++; end
      if (!load_ready) chk(1'b0, "upd_load_ready_timeout", 64'd0, 64'd1);
      load_valid = 1'b1;
      load_data  = 32'h1;
      step();
      load_valid = 1'b0;
      ref_mem[i] = ref_mem[i] + 32'h1;
    end
    n = 0;
    while (busy && n < 50) begin step(); n++; end
    chk(busy == 1'b0, "idle_after_update", 64'(busy), 64'd0);
    do_read(-1, 0, 1'b0);
`endif

    // Randomized loads, read-outs with random backpressure, and stalls
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < DEPTH; k++) load_buf[k] = $urandom;
      do_load(DEPTH, 1'b1);
      do_read(-1, 0, 1'b1);
      do_read(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 4)), 1'b1);
      if (it % 2 == 0) do_noop(2'd3);
    end

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
